dmem_arbiter: RTL and testbench

//  Two-port arbiter in front of the single-port data memory. Port 0 is the CPU load/store stage; port 1 is the debug/loader port.
//  At most one access is issued per cycle: round-robin on contention, plus an optional lock for atomic multi-access sequences.

---
 rtl/dmem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Port 0 is the CPU load/store stage, port 1 the debug/loader port.
// Round-robin on contention, optional lock for atomic sequences with a
// forced release after LOCK_MAX cycles. Memory-side strobes, addresses and
// write data are registered; read data returns through a registered
// response stage two cycles after the granting cycle.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_err,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;        // port of the most recent transfer
    logic               w_last_nxt;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_xfer0;
    logic               w_xfer1;
    logic               w_xfer;
    logic               w_lock_expire;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_rd_port;     // which port owns the read in the memory stage
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_lock_err;

    // Grant selection, transfer detection, next state and lock expiry.
    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_lock_expire = 1'b0;

        case (r_state)
            ST_ARB: begin
                if (req0 && req1) begin
                    // Contention: favour the port opposite the last transfer.
                    if (r_last) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end else if (req0) begin
                    w_gnt0 = 1'b1;
                end else if (req1) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            end
            ST_LOCK0: begin
                w_gnt0 = req0;
            end
            ST_LOCK1: begin
                w_gnt1 = req1;
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase

        w_xfer0 = req0 & w_gnt0;
        w_xfer1 = req1 & w_gnt1;
        w_xfer  = w_xfer0 | w_xfer1;

        if (w_xfer0) begin
            w_state_nxt = lock0 ? ST_LOCK0 : ST_ARB;
            w_last_nxt  = 1'b0;
        end else if (w_xfer1) begin
            w_state_nxt = lock1 ? ST_LOCK1 : ST_ARB;
            w_last_nxt  = 1'b1;
        end else begin
            w_last_nxt  = r_last;
        end

        // Forced release: owner becomes "last" so the other port is favoured.
        if ((r_state != ST_ARB) && (r_lock_cnt == CNT_LAST) && (w_state_nxt != ST_ARB)) begin
            w_lock_expire = 1'b1;
            w_state_nxt   = ST_ARB;
            w_last_nxt    = (r_state == ST_LOCK1);
        end else begin
            w_lock_expire = 1'b0;
        end

        if (w_xfer1) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_we    = we0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

    // Arbitration state, round-robin pointer and lock hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            if ((r_state == ST_ARB) || (w_state_nxt == ST_ARB)) begin
                r_lock_cnt <= '0;
            end else begin
                r_lock_cnt <= r_lock_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Memory issue stage: register the granted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_port   <= 1'b0;
        end else begin
            r_mem_read  <= w_xfer & ~w_sel_we;
            r_mem_write <= w_xfer & w_sel_we;
            if (w_xfer && !w_sel_we) begin
                r_rd_addr <= w_sel_addr;
                r_rd_port <= w_xfer1;
            end
            if (w_xfer && w_sel_we) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_wdata;
            end
        end
    end

    // Response stage: capture read data and raise the owning port's rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_rvalid0  <= r_mem_read & ~r_rd_port;
            r_rvalid1  <= r_mem_read & r_rd_port;
            r_lock_err <= w_lock_expire;
            if (r_mem_read) begin
                r_rdata <= mem_read_data;
            end
        end
    end

    assign gnt0              = w_gnt0;
    assign gnt1              = w_gnt1;
    assign rvalid0           = r_rvalid0;
    assign rvalid1           = r_rvalid1;
    assign rdata             = r_rdata;
    assign lock_err          = r_lock_err;
    assign mem_read          = r_mem_read;
    assign mem_write         = r_mem_write;
    assign mem_read_address  = r_rd_addr;
    assign mem_write_address = r_wr_addr;
    assign mem_write_data    = r_wr_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, reference memory
// image and a scoreboard of expected read responses (port, data, cycle).
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, lock_err, mem_read, mem_write;
    logic [DW-1:0] rdata, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_read_address, mem_write_address;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .lock_err(lock_err),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory: combinational read, write commits on the edge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_write_address[7:0]] = mem_write_data;
    end
    assign mem_read_data = mem[mem_read_address[7:0]];

    // Response monitor: every rvalid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rvalid0 && rvalid1) begin
            checks++;
            errors++;
            $display("FAIL both_rvalid got 2'b11 exp at most one");
        end
        if (rvalid0 || rvalid1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid got rvalid0=%b rvalid1=%b exp none at cycle %0d", rvalid0, rvalid1, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rvalid1 !== e.port || rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL response got port=%b data=%h cyc=%0d exp port=%b data=%h cyc=%0d",
                             rvalid1, rdata, cyc, e.port, e.data, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_rvalid got none exp port=%b data=%h at cycle %0d", sb[0].port, sb[0].data, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, lock_err, mem_read, mem_write} !== 7'b0 ||
            rdata !== '0 || mem_read_address !== '0 || mem_write_address !== '0 || mem_write_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b rdata=%h ra=%h wa=%h wd=%h exp all zero",
                     {gnt0, gnt1, rvalid0, rvalid1, lock_err, mem_read, mem_write},
                     rdata, mem_read_address, mem_write_address, mem_write_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t1_gnt got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[5], cyc + 2});
        tick();
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_read_address !== 32'd5) begin
            errors++;
            $display("FAIL t1_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=5", mem_read, mem_write, mem_read_address);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_contention;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic exp_port;
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
            addr0 = 32'(10 + i); addr1 = 32'(20 + i);
            exp_port = (i % 2 == 1);
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1} !== {~exp_port, exp_port}) begin
                errors++;
                $display("FAIL t2_gnt%0d got %b exp %b", i, {gnt0, gnt1}, {~exp_port, exp_port});
            end
            sb.push_back(exp_t'{exp_port, exp_port ? ref_mem[20 + i] : ref_mem[10 + i], cyc + 2});
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_write_read;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd8; wdata1 = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL t3_wgnt got %b exp %b", {gnt0, gnt1}, 2'b01);
        end
        ref_mem[8] = 32'h0000_1234;
        tick();
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_address !== 32'd8 || mem_write_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL t3_wissue got wr=%b rd=%b addr=%h data=%h exp wr=1 rd=0 addr=8 data=1234",
                     mem_write, mem_read, mem_write_address, mem_write_data);
        end
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t3_rgnt got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[8], cyc + 2});
        tick();
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_lock;
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'd5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t4_lockgnt got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[5], cyc + 2});
        tick();
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++;
                $display("FAIL t4_held%0d got %b exp %b", i, {gnt0, gnt1}, 2'b00);
            end
            tick();
        end
        req0 = 1'b1; lock0 = 1'b0; addr0 = 32'd10;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t4_unlock got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[10], cyc + 2});
        tick();
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL t4_gnt1 got %b exp %b", {gnt0, gnt1}, 2'b01);
        end
        sb.push_back(exp_t'{1'b1, ref_mem[8], cyc + 2});
        tick();
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_lock_timeout;
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'd5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t5_lockgnt got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[5], cyc + 2});
        tick();
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1 !== 1'b0 || lock_err !== 1'b0) begin
                errors++;
                $display("FAIL t5_hold%0d got gnt1=%b lock_err=%b exp 0 0", i, gnt1, lock_err);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || lock_err !== 1'b1) begin
            errors++;
            $display("FAIL t5_expire got gnt1=%b lock_err=%b exp 1 1", gnt1, lock_err);
        end
        sb.push_back(exp_t'{1'b1, ref_mem[20], cyc + 2});
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (lock_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_pulse got lock_err=%b exp 0", lock_err);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_inflight;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t6_gnt got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        tick();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_read !== 1'b0) begin
                errors++;
                $display("FAIL t6_drop%0d got rvalid0=%b rvalid1=%b mem_read=%b exp 0 0 0", i, rvalid0, rvalid1, mem_read);
            end
            tick();
        end
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'd5; addr1 = 32'd20;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL t6_release got %b exp %b", {gnt0, gnt1}, 2'b10);
        end
        sb.push_back(exp_t'{1'b0, ref_mem[5], cyc + 2});
        tick();
        idle_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC000_0000 | 32'(i * 3);
            ref_mem[i] = 32'hC000_0000 | 32'(i * 3);
        end
        mem[5]     = 32'h0000_00A5;
        ref_mem[5] = 32'h0000_00A5;

        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_lock();
        test_lock_timeout();
        test_reset_inflight();

        tick(); tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
